// File: rtl/division_unit_pkg.sv
// Shared constants for the iterative divider: FSM encodings, iteration count
// and the {HI, LO} field split of the 64-bit result.
package division_unit_pkg;

    localparam int unsigned DIV_WIDTH      = 32;
    localparam int unsigned DIV_ITERATIONS = 32;

    // 2-bit FSM encodings
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ZERO = 2'd1;
    localparam logic [1:0] ST_BUSY = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // result = {HI = remainder, LO = quotient}
    localparam int unsigned RESULT_LO_LSB = 0;
    localparam int unsigned RESULT_LO_MSB = DIV_WIDTH - 1;
    localparam int unsigned RESULT_HI_LSB = DIV_WIDTH;
    localparam int unsigned RESULT_HI_MSB = 2 * DIV_WIDTH - 1;

endpackage

// File: rtl/division_step.sv
// One restoring-division step: shift {rem, quo} left, then subtract the
// divisor from the partial remainder if it fits and record the quotient bit.
module division_step
    import division_unit_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    // One extra bit: a shifted remainder can exceed WIDTH bits when the
    // unsigned divisor is above 2^(WIDTH-1).
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] divisor_ext;
    logic           fits;

    always_comb begin
        shifted     = {rem, quo[WIDTH-1]};
        divisor_ext = {1'b0, divisor};
        fits        = (shifted >= divisor_ext);
        if (fits) begin
            rem_next = WIDTH'(shifted - divisor_ext);
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_next = shifted[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/division_unit.sv
// Iterative restoring divider for DIV/DIVU: one quotient bit per cycle,
// stalls the pipeline while busy and pulses ready with {HI, LO}.
module division_unit
    import division_unit_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_ITERATIONS
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               signed_op,
    input  logic               annul,
    input  logic [WIDTH-1:0]   operand_a,
    input  logic [WIDTH-1:0]   operand_b,
    output logic               stall,
    output logic               ready,
    output logic [2*WIDTH-1:0] result
);

    localparam int unsigned     CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      count_q, count_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   divisor_q, divisor_d;
    logic               qneg_q, qneg_d;
    logic               rneg_q, rneg_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               ready_q, ready_d;

    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;
    logic [WIDTH-1:0]   step_rem;
    logic [WIDTH-1:0]   step_quo;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    // Magnitudes wrap for the most negative value, so |0x80000000| = 0x80000000.
    always_comb begin
        a_neg = signed_op & operand_a[WIDTH-1];
        b_neg = signed_op & operand_b[WIDTH-1];
        a_abs = a_neg ? -operand_a : operand_a;
        b_abs = b_neg ? -operand_b : operand_b;
    end

    division_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (divisor_q),
        .rem_next (step_rem),
        .quo_next (step_quo)
    );

    // Sign fix-up is applied to the final step's output so the result is
    // already registered when DONE is entered.
    always_comb begin
        quo_fix = qneg_q ? -step_quo : step_quo;
        rem_fix = rneg_q ? -step_rem : step_rem;
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        divisor_d = divisor_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
        result_d  = result_q;
        ready_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !annul) begin
                    qneg_d    = a_neg ^ b_neg;
                    rneg_d    = a_neg;
                    divisor_d = b_abs;
                    count_d   = '0;
                    if (operand_b == '0) begin
                        // Raw dividend is parked in rem for the zero-divisor result.
                        rem_d   = operand_a;
                        quo_d   = '0;
                        state_d = ST_ZERO;
                    end else begin
                        rem_d   = '0;
                        quo_d   = a_abs;
                        state_d = ST_BUSY;
                    end
                end
            end
            ST_ZERO: begin
                result_d = {rem_q, {WIDTH{1'b1}}};
                ready_d  = 1'b1;
                state_d  = ST_DONE;
            end
            ST_BUSY: begin
                rem_d   = step_rem;
                quo_d   = step_quo;
                count_d = count_q + CW'(1);
                if (count_q == LAST) begin
                    result_d = {rem_fix, quo_fix};
                    ready_d  = 1'b1;
                    count_d  = '0;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Flush wins over everything: no result write, no ready pulse.
        if (annul) begin
            state_d  = ST_IDLE;
            count_d  = '0;
            result_d = result_q;
            ready_d  = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
            result_q  <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            divisor_q <= divisor_d;
            qneg_q    <= qneg_d;
            rneg_q    <= rneg_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    always_comb begin
        stall  = start & ~annul & (state_q != ST_DONE);
        ready  = ready_q;
        result = result_q;
    end

endmodule

// File: tb/tb_division_unit.sv
// Directed self-checking bench for division_unit: latency, stall window,
// signed/unsigned results, divide-by-zero, annul, back-to-back and reset.
module tb_division_unit;

    logic        clock;
    logic        reset;
    logic        start;
    logic        signed_op;
    logic        annul;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        stall;
    logic        ready;
    logic [63:0] result;

    int passed;
    int total;

    division_unit #(
        .WIDTH (32)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .signed_op (signed_op),
        .annul     (annul),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .stall     (stall),
        .ready     (ready),
        .result    (result)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Runs one divide from an idle unit. Entered and left 1 time unit after
    // a rising edge. lat = -1 if no ready within the cycle budget.
    task automatic divide(input logic [31:0] a, input logic [31:0] b, input logic sg,
                          output int lat, output int stalls, output logic [63:0] res,
                          output logic extra_ready);
        start     = 1'b1;
        signed_op = sg;
        operand_a = a;
        operand_b = b;
        lat       = -1;
        stalls    = 0;
        res       = '0;
        #1;
        if (stall) stalls++;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clock);
            #1;
            if (stall) stalls++;
            if (ready) begin
                lat = c;
                res = result;
                break;
            end
        end
        start = 1'b0;
        @(posedge clock);
        #1;
        extra_ready = ready;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        annul = 1'b0;
        signed_op = 1'b0;
        operand_a = '0;
        operand_b = '0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        total++;
        if (ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", ready);
        else passed++;
        total++;
        if (result !== 64'h0) $display("FAIL reset_result: got %h want 0", result);
        else passed++;
        total++;
        if (stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", stall);
        else passed++;
    endtask

    task automatic test_divu_basic();
        int lat, stalls;
        logic [63:0] res;
        logic extra;
        divide(32'h00000064, 32'h00000007, 1'b0, lat, stalls, res, extra);
        total++;
        if (lat !== 33) $display("FAIL divu_latency: got %0d want 33", lat);
        else passed++;
        total++;
        if (stalls !== 33) $display("FAIL divu_stall_cycles: got %0d want 33", stalls);
        else passed++;
        total++;
        if (res !== 64'h00000002_0000000E) $display("FAIL divu_result: got %h want 000000020000000e", res);
        else passed++;
        total++;
        if (extra !== 1'b0) $display("FAIL divu_ready_pulse: got %b want 0", extra);
        else passed++;
    endtask

    task automatic test_div_signed();
        int lat, stalls;
        logic [63:0] res;
        logic extra;
        divide(32'hFFFFFF9C, 32'h00000007, 1'b1, lat, stalls, res, extra);
        total++;
        if (res !== 64'hFFFFFFFE_FFFFFFF2) $display("FAIL div_neg100_by7: got %h want fffffffefffffff2", res);
        else passed++;
        total++;
        if (lat !== 33) $display("FAIL div_signed_latency: got %0d want 33", lat);
        else passed++;
        divide(32'hFFFFFFFB, 32'h00000006, 1'b1, lat, stalls, res, extra);
        total++;
        if (res !== 64'hFFFFFFFB_00000000) $display("FAIL div_neg5_by6: got %h want fffffffb00000000", res);
        else passed++;
    endtask

    task automatic test_overflow();
        int lat, stalls;
        logic [63:0] res;
        logic extra;
        divide(32'h80000000, 32'hFFFFFFFF, 1'b1, lat, stalls, res, extra);
        total++;
        if (res !== 64'h00000000_80000000) $display("FAIL div_min_by_m1: got %h want 0000000080000000", res);
        else passed++;
        divide(32'h80000000, 32'hFFFFFFFF, 1'b0, lat, stalls, res, extra);
        total++;
        if (res !== 64'h80000000_00000000) $display("FAIL divu_min_by_max: got %h want 8000000000000000", res);
        else passed++;
    endtask

    task automatic test_div_zero();
        int lat, stalls;
        logic [63:0] res;
        logic extra;
        divide(32'h12345678, 32'h00000000, 1'b0, lat, stalls, res, extra);
        total++;
        if (lat !== 2) $display("FAIL zero_latency: got %0d want 2", lat);
        else passed++;
        total++;
        if (stalls !== 2) $display("FAIL zero_stall_cycles: got %0d want 2", stalls);
        else passed++;
        total++;
        if (res !== 64'h12345678_FFFFFFFF) $display("FAIL zero_result: got %h want 12345678ffffffff", res);
        else passed++;
    endtask

    task automatic test_annul();
        int lat, stalls;
        logic [63:0] res;
        logic extra;
        logic saw_ready;
        saw_ready = 1'b0;
        start = 1'b1;
        signed_op = 1'b0;
        operand_a = 32'h00000064;
        operand_b = 32'h00000007;
        #1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clock);
            #1;
            if (ready) saw_ready = 1'b1;
        end
        annul = 1'b1;
        #1;
        total++;
        if (stall !== 1'b0) $display("FAIL annul_stall_drop: got %b want 0", stall);
        else passed++;
        @(posedge clock);
        #1;
        annul = 1'b0;
        start = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clock);
            #1;
            if (ready) saw_ready = 1'b1;
        end
        total++;
        if (saw_ready !== 1'b0) $display("FAIL annul_no_ready: got %b want 0", saw_ready);
        else passed++;
        total++;
        if (result !== 64'h12345678_FFFFFFFF) $display("FAIL annul_result_kept: got %h want 12345678ffffffff", result);
        else passed++;
        divide(32'hFFFFFFFF, 32'h00000010, 1'b0, lat, stalls, res, extra);
        total++;
        if (lat !== 33) $display("FAIL after_annul_latency: got %0d want 33", lat);
        else passed++;
        total++;
        if (res !== 64'h0000000F_0FFFFFFF) $display("FAIL after_annul_result: got %h want 0000000f0fffffff", res);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int first_c, second_c, n_ready;
        logic [63:0] first_res, second_res;
        first_c = -1;
        second_c = -1;
        n_ready = 0;
        first_res = '0;
        second_res = '0;
        start = 1'b1;
        signed_op = 1'b0;
        operand_a = 32'h00000007;
        operand_b = 32'h00000002;
        #1;
        for (int c = 1; c <= 120; c++) begin
            @(posedge clock);
            #1;
            if (ready) begin
                n_ready++;
                if (first_c < 0) begin
                    first_c = c;
                    first_res = result;
                    operand_a = 32'h000003E8;
                    operand_b = 32'h0000000A;
                end else begin
                    second_c = c;
                    second_res = result;
                    break;
                end
            end
        end
        start = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        if (ready) n_ready++;
        total++;
        if (first_c !== 33) $display("FAIL b2b_first_latency: got %0d want 33", first_c);
        else passed++;
        total++;
        if (second_c !== 67) $display("FAIL b2b_second_latency: got %0d want 67", second_c);
        else passed++;
        total++;
        if (n_ready !== 2) $display("FAIL b2b_ready_count: got %0d want 2", n_ready);
        else passed++;
        total++;
        if (first_res !== 64'h00000001_00000003) $display("FAIL b2b_first_result: got %h want 0000000100000003", first_res);
        else passed++;
        total++;
        if (second_res !== 64'h00000000_00000064) $display("FAIL b2b_second_result: got %h want 0000000000000064", second_res);
        else passed++;
    endtask

    task automatic test_reset_mid_busy();
        logic saw_ready;
        saw_ready = 1'b0;
        start = 1'b1;
        signed_op = 1'b1;
        operand_a = 32'hFFFFFF9C;
        operand_b = 32'h00000007;
        #1;
        repeat (5) @(posedge clock);
        #1;
        reset = 1'b1;
        start = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        total++;
        if (result !== 64'h0) $display("FAIL midreset_result: got %h want 0", result);
        else passed++;
        total++;
        if (stall !== 1'b0) $display("FAIL midreset_stall: got %b want 0", stall);
        else passed++;
        for (int c = 0; c < 40; c++) begin
            @(posedge clock);
            #1;
            if (ready) saw_ready = 1'b1;
        end
        total++;
        if (saw_ready !== 1'b0) $display("FAIL midreset_no_ready: got %b want 0", saw_ready);
        else passed++;
    endtask

    initial begin
        passed = 0;
        total = 0;
        reset = 1'b1;
        start = 1'b0;
        annul = 1'b0;
        signed_op = 1'b0;
        operand_a = '0;
        operand_b = '0;
        test_reset();
        test_divu_basic();
        test_div_signed();
        test_overflow();
        test_div_zero();
        test_annul();
        test_back_to_back();
        test_reset_mid_busy();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
